// File: rtl/quad_cmd_pkg.sv
// quad_cmd_pkg: shared state/error types, ack code and opcodes for the remote command sequencer
package quad_cmd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_NACK = 2'b01, ERR_TIMEOUT = 2'b10} err_t;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] STPTCH  = 8'h02;
  localparam logic [7:0] STRLL   = 8'h03;
  localparam logic [7:0] STYW    = 8'h04;
  localparam logic [7:0] STTHRST = 8'h05;
  localparam logic [7:0] CAL     = 8'h06;
  localparam logic [7:0] EMER    = 8'h07;
  localparam logic [7:0] MTSOFF  = 8'h08;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead fifo with flush; a write on full is accepted when a read happens the same cycle
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_wr, do_rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_rd = rd && !empty && !clr;
  assign do_wr = wr && !clr && (!full || do_rd);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_wr);
      rp  <= rp + AW'(do_rd);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/remote_cmd_sequencer.sv
// remote_cmd_sequencer: queues commands and issues them to RemoteComm with ack check, retry and timeout
module remote_cmd_sequencer
  import quad_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_cmd,
  input  logic [15:0] push_data,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  input  logic        abort,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic [1:0]  err
);
  localparam int TW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] retry;
  logic [7:0] resp_q;
  logic [23:0] head;
  logic pop, timeout, fail;
  err_t fail_err;
  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
    .clk(clk), .rst(rst), .clr(abort), .wr(push), .wdata({push_cmd, push_data}),
    .rd(pop), .rdata(head), .full(full), .empty(empty)
  );
  assign pop          = state == LOAD && !abort;
  assign timeout      = tcnt >= TW'(TIMEOUT_CYC - 1);
  assign busy         = state != IDLE;
  assign clr_resp_rdy = state == WAIT_RESP && resp_rdy && !rst && !abort;
  assign fail_err     = state == CHECK ? ERR_NACK : ERR_TIMEOUT;
  assign fail = !abort && ((state == WAIT_SENT && !cmd_sent && timeout) ||
                           (state == WAIT_RESP && !resp_rdy && timeout) ||
                           (state == CHECK && resp_q != ACK));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      send_cmd <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      ack_ok   <= 1'b0;
      err      <= ERR_NONE;
      cmd      <= '0;
      data     <= '0;
      tcnt     <= '0;
      retry    <= '0;
      resp_q   <= '0;
    end else begin
      send_cmd <= 1'b0;
      done     <= 1'b0;
      overflow <= push && full && !pop && !abort;
      tcnt     <= (state inside {WAIT_SENT, WAIT_RESP}) ? tcnt + TW'(tcnt != '1) : '0;
      if (abort) state <= IDLE;
      else case (state)
        IDLE:      if (!empty) state <= LOAD;
        LOAD: begin
          {cmd, data} <= head;
          retry       <= '0;
          send_cmd    <= 1'b1;
          state       <= SEND;
        end
        SEND:      state <= WAIT_SENT;
        WAIT_SENT: if (cmd_sent) state <= WAIT_RESP;
        WAIT_RESP: if (resp_rdy) begin
          resp_q <= resp;
          state  <= CHECK;
        end
        CHECK:     if (resp_q == ACK) begin
          done   <= 1'b1;
          ack_ok <= 1'b1;
          err    <= ERR_NONE;
          state  <= IDLE;
        end
        default:   state <= IDLE;
      endcase
      if (fail && retry < RW'(MAX_RETRY)) begin
        retry    <= retry + RW'(1);
        send_cmd <= 1'b1;
        state    <= SEND;
      end else if (fail) begin
        done   <= 1'b1;
        ack_ok <= 1'b0;
        err    <= fail_err;
        state  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// tb_remote_cmd_sequencer: table vectors, corner sequences and randomized scoreboard for the sequencer
module tb_remote_cmd_sequencer;
  import quad_cmd_pkg::*;
  localparam int MR = 2;
  logic clk = 0, rst = 1, push = 0, abort = 0, cmd_sent = 0, resp_rdy = 0;
  logic [7:0] push_cmd = 0, resp = 0;
  logic [15:0] push_data = 0;
  logic full, empty, overflow, send_cmd, clr_resp_rdy, busy, done, ack_ok;
  logic [7:0] cmd;
  logic [15:0] data;
  logic [1:0] err;
  int n_vec = 0, n_err = 0, cyc = 0, n_send = 0, n_clr = 0, n_done = 0, n_ovf = 0;
  int plan[$];
  int send_t[$];
  logic [23:0] sent_log[$];
  logic [2:0] done_log[$];
  typedef struct {
    logic [7:0] c; logic [15:0] d;
    int r0; int r1; int r2;
    int sends; int clrs; logic ack; logic [1:0] err;
  } vec_t;

  remote_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYC(100), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
    .full(full), .empty(empty), .overflow(overflow), .abort(abort),
    .cmd(cmd), .data(data), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (send_cmd) begin n_send++; sent_log.push_back({cmd, data}); send_t.push_back(cyc); end
    if (clr_resp_rdy) n_clr++;
    if (done) begin n_done++; done_log.push_back({ack_ok, err}); end
    if (overflow) n_ovf++;
  end

  // RemoteComm stand-in: plan code -1 = silent, -2 = cmd_sent only, 0..255 = response byte
  initial begin
    int r;
    bit got;
    forever begin
      @(negedge clk);
      if (send_cmd) begin
        r = plan.size() > 0 ? plan.pop_front() : 'hA5;
        if (r != -1) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1 cmd_sent = 1;
          @(posedge clk); #1 cmd_sent = 0;
          if (r >= 0) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 resp = r[7:0]; resp_rdy = 1;
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin @(negedge clk); got = clr_resp_rdy; end
            @(posedge clk); #1 resp_rdy = 0;
          end
        end
      end
    end
  end

  initial begin #900000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] c, input logic [15:0] d);
    push = 1; push_cmd = c; push_data = d;
    tick();
    push = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin smp(); k++; end
    if (n_done < target) chk({nm, "_wait"}, 64'(n_done), 64'(target));
  endtask

  function automatic int pick();
    int v;
    v = $urandom_range(0, 9);
    if (v < 4) return 'hA5;
    if (v == 8) return -1;
    if (v == 9) return -2;
    v = $urandom_range(0, 255);
    return v == 'hA5 ? 0 : v;
  endfunction

  initial begin
    vec_t tbl[9];
    int a[3];
    int s0, c0, d0, o0, l0, nb, r;
    bit ok;
    logic [23:0] cd;
    logic [2:0] res;
    logic [23:0] exp_sent[$];
    logic [2:0] exp_done[$];
    tbl[0] = '{CAL,     16'h0000, 'hA5, 0,    0,    1, 1, 1'b1, 2'b00};
    tbl[1] = '{8'hED,   16'hBEEF, 'h00, 'h00, 'h00, 3, 3, 1'b0, 2'b01};
    tbl[2] = '{STPTCH,  16'h1234, 'h00, 'hA5, 0,    2, 2, 1'b1, 2'b00};
    tbl[3] = '{STRLL,   16'hABCD, 'h11, 'h22, 'hA5, 3, 3, 1'b1, 2'b00};
    tbl[4] = '{STYW,    16'h0001, -1,   -1,   -1,   3, 0, 1'b0, 2'b10};
    tbl[5] = '{STTHRST, 16'hFFFF, -1,   'hA5, 0,    2, 1, 1'b1, 2'b00};
    tbl[6] = '{EMER,    16'h8000, 'h00, -1,   'h5A, 3, 2, 1'b0, 2'b01};
    tbl[7] = '{MTSOFF,  16'h7FFF, -1,   -1,   'h00, 3, 1, 1'b0, 2'b01};
    tbl[8] = '{8'h42,   16'h0042, 'h00, -1,   -1,   3, 1, 1'b0, 2'b10};
    tick(3);
    smp();
    chk("reset", {busy, empty, full, send_cmd, done, ack_ok, err, overflow, clr_resp_rdy, cmd, data},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000});
    tick();
    rst = 0;
    tick(2);

    foreach (tbl[i]) begin
      a = '{tbl[i].r0, tbl[i].r1, tbl[i].r2};
      s0 = n_send; c0 = n_clr; d0 = n_done;
      plan.delete();
      foreach (a[k]) plan.push_back(a[k]);
      do_push(tbl[i].c, tbl[i].d);
      wait_done(d0 + 1, 600, "vec");
      chk("sends", 64'(n_send - s0), 64'(tbl[i].sends));
      chk("clr_resp_rdy", 64'(n_clr - c0), 64'(tbl[i].clrs));
      chk("done_cnt", 64'(n_done - d0), 1);
      chk("ack_err", done_log[$], {tbl[i].ack, tbl[i].err});
      chk("cmd_data", sent_log[$], {tbl[i].c, tbl[i].d});
      for (int k = 0; k + 1 < tbl[i].sends; k++)
        if (a[k] < 0) chk("timeout_gap", 64'((send_t[s0+k+1] - send_t[s0+k]) inside {[99:103]}), 1);
      tick(3);
      smp();
      chk("hold", {busy, ack_ok, err}, {1'b0, tbl[i].ack, tbl[i].err});
      plan.delete();
      tick();
    end

    plan.delete(); plan.push_back(-1); plan.push_back('hA5);
    d0 = n_done; o0 = n_ovf; l0 = sent_log.size();
    do_push(EMER, 16'h0BAD);
    tick(4);
    for (int i = 0; i < 5; i++) begin
      push = 1; push_cmd = 8'h10 + 8'(i); push_data = 16'h1000 + 16'(i);
      smp();
      if (i == 4) chk("full_before_5th", full, 1);
      tick();
    end
    push = 0;
    smp();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", 64'(n_ovf - o0), 1);
    tick();
    wait_done(d0 + 5, 1500, "ovf");
    chk("ovf_sends", 64'(sent_log.size() - l0), 6);
    for (int i = 0; i < 4; i++) chk("ovf_order", sent_log[l0+2+i], {8'h10 + 8'(i), 16'h1000 + 16'(i)});
    tick(2);

    plan.delete(); plan.push_back(-2);
    d0 = n_done; s0 = n_send;
    do_push(CAL, 16'h0001);
    tick(3);
    do_push(STRLL, 16'h0002);
    do_push(STYW, 16'h0003);
    tick(12);
    smp();
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_queued", empty, 0);
    tick();
    abort = 1; push = 1; push_cmd = STTHRST; push_data = 16'h0004;
    tick();
    abort = 0; push = 0;
    smp();
    chk("abort_idle", busy, 0);
    chk("abort_empty", empty, 1);
    tick(30);
    smp();
    chk("abort_no_done", 64'(n_done - d0), 0);
    chk("abort_no_send", 64'(n_send - s0), 1);
    tick();

    plan.delete(); plan.push_back(-1);
    d0 = n_done;
    do_push(MTSOFF, 16'h5555);
    tick(5);
    smp();
    chk("pre_rst_busy", {busy, ack_ok}, 2'b11);
    tick();
    rst = 1;
    tick();
    smp();
    chk("rst_mid", {busy, empty, full, send_cmd, done, ack_ok, err, overflow, clr_resp_rdy, cmd, data},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000});
    tick();
    rst = 0;
    tick(20);
    smp();
    chk("rst_no_done", 64'(n_done - d0), 0);
    tick();

    for (int b = 0; b < 25; b++) begin
      nb = $urandom_range(1, 4);
      plan.delete(); exp_sent.delete(); exp_done.delete();
      l0 = sent_log.size(); d0 = n_done;
      for (int j = 0; j < nb; j++) begin
        cd = 24'($urandom);
        ok = 0;
        res = 3'b000;
        for (int k = 0; k <= MR && !ok; k++) begin
          r = pick();
          plan.push_back(r);
          exp_sent.push_back(cd);
          ok = r == 'hA5;
          res = ok ? 3'b100 : (r < 0 ? 3'b010 : 3'b001);
        end
        exp_done.push_back(res);
        do_push(cd[23:16], cd[15:0]);
      end
      wait_done(d0 + nb, 400 * nb, "rnd");
      chk("rnd_sends", 64'(sent_log.size() - l0), 64'(exp_sent.size()));
      foreach (exp_sent[k]) chk("rnd_cmd_data", sent_log[l0+k], exp_sent[k]);
      foreach (exp_done[k]) chk("rnd_ack_err", done_log[d0+k], exp_done[k]);
      tick(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
